// File: rtl/dmem_pipe.sv
// dmem_pipe -- parameterised data memory for the MEM stage.
//
// Takes one request per valid/ready handshake. Writes complete in the accepting
// cycle, and the block stays ready for the next request. A read takes a
// snapshot of the addressed word at acceptance. The result comes back as a
// one-cycle resp_valid pulse RD_LAT edges later. The block is busy from
// acceptance until the edge after that pulse. Only one read is outstanding at
// a time. The full address is decoded: an out-of-range write is dropped, and
// an out-of-range read returns 0 with resp_err set.
//
// Optional build macro DMEM_BYTE_EN adds a per-byte write enable (req_be).
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_wr                1 = write, 0 = read
//   req_addr, req_wdata   word address, write data
//   req_be                byte write enables (DMEM_BYTE_EN builds only)
//   resp_valid            one-cycle read response strobe, no backpressure
//   resp_rdata, resp_err  read data / out-of-range flag while resp_valid
//   busy                  ~req_ready
module dmem_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 32,
  parameter int RD_LAT   = 1,
  parameter int INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Elaboration-time parameter checks
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("dmem_pipe: DEPTH must be in 1..2**ADDR_W");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("dmem_pipe: RD_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] hold_data;
  logic              hold_err;

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_vec [DEPTH];

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  // The full-width compare stops addresses >= DEPTH from aliasing onto low entries.
  assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = req_addr[IDX_W-1:0];
  assign wr_en    = rst_n && req_valid && req_ready && req_wr && in_range;
  assign rd_word  = in_range ? rd_vec[idx] : '0;

`ifdef DMEM_BYTE_EN
  if (DATA_W % 8 != 0) begin : g_bad_be
    $error("dmem_pipe: DATA_W must be a multiple of 8 with DMEM_BYTE_EN");
  end
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_be
    assign wmask[8*b +: 8] = {8{req_be[b]}};
  end
`else
  assign wmask = '1;
`endif

  // One register per word. Contents are set only at time zero and are not
  // touched by reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [DATA_W-1:0] q = (INIT_IDX != 0) ? DATA_W'(i) : '0;
    always_ff @(posedge clk) begin
      if (wr_en && idx == IDX_W'(i))
        q <= (q & ~wmask) | (req_wdata & wmask);
    end
    assign rd_vec[i] = q;
  end

  // The response outputs are registered, and they load at the edge that enters
  // RESP. WAIT therefore spans RD_LAT cycles, counted RD_LAT-1 down to 0. The
  // RESP cycle is the cycle that presents the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !req_wr) begin
            hold_data <= rd_word;
            hold_err  <= ~in_range;
            cnt       <= 2'(RD_LAT - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= hold_data;
            resp_err   <= hold_err;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe -- self-checking bench for dmem_pipe.
// Instance 0 runs with RD_LAT = 1 and instance 1 with RD_LAT = 3. Both use the
// default DEPTH of 32. A reference model tracks memory contents and the
// expected handshake and response timing from the acceptance edge.
module tb_dmem_pipe;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_wr     [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic [1:0]  req_be     [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int tests, fails;
  bit chk_en;

  // Reference model state
  logic [15:0] mm [2][32];   // memory contents
  int          es [2];       // edges since read acceptance, -1 = none pending
  logic        ev [2];       // expected resp_valid
  logic [15:0] ed [2];       // expected resp_rdata
  logic        ee [2];       // expected resp_err
  logic [15:0] sd [2];       // read snapshot
  logic        se [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_pipe #(.RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_BYTE_EN
    .req_be(req_be[0]),
`endif
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]));

  dmem_pipe #(.RD_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_BYTE_EN
    .req_be(req_be[1]),
`endif
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]));

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the model, using the request that was presented at that edge.
  task automatic model_edge(int k);
    logic        acc;
    logic [15:0] m;
    if (!rst_n[k]) begin
      es[k] = -1; ev[k] = 1'b0; ed[k] = '0; ee[k] = 1'b0;
    end else begin
      acc   = req_valid[k] && (es[k] < 0);
      ev[k] = 1'b0;
      if (es[k] >= 0) begin
        es[k]++;
        if (es[k] == lat_of(k)) begin
          ev[k] = 1'b1; ed[k] = sd[k]; ee[k] = se[k];
        end else if (es[k] > lat_of(k)) begin
          es[k] = -1;
        end
      end
      m = {{8{req_be[k][1]}}, {8{req_be[k][0]}}};
`ifndef DMEM_BYTE_EN
      m = 16'hFFFF;
`endif
      if (acc && req_wr[k]) begin
        if (req_addr[k] < 16'd32)
          mm[k][req_addr[k][4:0]] = (mm[k][req_addr[k][4:0]] & ~m) | (req_wdata[k] & m);
      end else if (acc) begin
        sd[k] = (req_addr[k] < 16'd32) ? mm[k][req_addr[k][4:0]] : 16'h0000;
        se[k] = (req_addr[k] >= 16'd32);
        es[k] = 0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) mm[k][i] = 16'(i);
      es[k] = -1; ev[k] = 1'b0; ed[k] = '0; ee[k] = 1'b0; sd[k] = '0; se[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_edge(k);
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready%0d", k), 32'(req_ready[k]), 32'(es[k] < 0));
        chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(es[k] >= 0));
        chk($sformatf("resp_valid%0d", k), 32'(resp_valid[k]), 32'(ev[k]));
        if (ev[k]) begin
          chk($sformatf("resp_rdata%0d", k), 32'(resp_rdata[k]), 32'(ed[k]));
          chk($sformatf("resp_err%0d", k), 32'(resp_err[k]), 32'(ee[k]));
        end
      end
    end
  end

  task automatic do_write(int k, logic [15:0] a, logic [15:0] d, logic [1:0] be);
    req_valid[k] = 1'b1; req_wr[k] = 1'b1; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be;
    @(posedge clk);
    #1 req_valid[k] = 1'b0; req_wr[k] = 1'b0;
  endtask

  // Issues a read while the DUT is idle. Records the response and counts the
  // busy cycles, with a bounded wait.
  task automatic do_read(int k, logic [15:0] a, output logic [15:0] d, output logic e,
                         output int nb, output int nv);
    d = '0; e = 1'b0; nb = 0; nv = 0;
    req_valid[k] = 1'b1; req_wr[k] = 1'b0; req_addr[k] = a;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid[k]) begin nv++; d = resp_rdata[k]; e = resp_err[k]; end
      if (!req_ready[k]) nb++;
      else break;
    end
  endtask

  logic [15:0] d;
  logic        e;
  int          nb, nv;

  initial begin
    tests = 0; fails = 0; chk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_wr[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = 2'b11;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b1;
      chk($sformatf("rst_valid%0d", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("rst_rdata%0d", k), 32'(resp_rdata[k]), 32'd0);
      chk($sformatf("rst_err%0d", k), 32'(resp_err[k]), 32'd0);
      chk($sformatf("rst_ready%0d", k), 32'(req_ready[k]), 32'd1);
    end
    chk_en = 1'b1;

    // RD_LAT = 1 basic read
    do_read(0, 16'd5, d, e, nb, nv);
    chk("rd5_data", 32'(d), 32'h0005);
    chk("rd5_err", 32'(e), 32'd0);
    chk("rd5_busy", 32'(nb), 32'd2);
    chk("rd5_pulses", 32'(nv), 32'd1);
    chk("model_rd5", 32'(ed[0]), 32'h0005);

`ifdef DMEM_BYTE_EN
    do_write(0, 16'd3, 16'h12AB, 2'b01);
    do_read(0, 16'd3, d, e, nb, nv);
    chk("be01_data", 32'(d), 32'h00AB);
    chk("model_be01", 32'(mm[0][3]), 32'h00AB);
    do_write(0, 16'd3, 16'hFFFF, 2'b00);
    do_read(0, 16'd3, d, e, nb, nv);
    chk("be00_data", 32'(d), 32'h00AB);
`endif

    // Read-after-write on the next edge
    do_write(0, 16'd7, 16'hBEEF, 2'b11);
    do_read(0, 16'd7, d, e, nb, nv);
    chk("raw7_data", 32'(d), 32'hBEEF);
    chk("model_raw7", 32'(mm[0][7]), 32'hBEEF);

    // Back-to-back writes
    do_write(0, 16'd1, 16'h1111, 2'b11);
    do_write(0, 16'd2, 16'h2222, 2'b11);
    do_write(0, 16'd3, 16'h3333, 2'b11);
    do_read(0, 16'd1, d, e, nb, nv); chk("b2b1", 32'(d), 32'h1111);
    do_read(0, 16'd2, d, e, nb, nv); chk("b2b2", 32'(d), 32'h2222);
    do_read(0, 16'd3, d, e, nb, nv); chk("b2b3", 32'(d), 32'h3333);

    // Out-of-range addresses
    do_write(0, 16'd40, 16'h1234, 2'b11);
    do_read(0, 16'd8, d, e, nb, nv);
    chk("oor_noalias", 32'(d), 32'h0008);
    chk("oor_noalias_err", 32'(e), 32'd0);
    do_read(0, 16'd40, d, e, nb, nv);
    chk("oor40_data", 32'(d), 32'd0);
    chk("oor40_err", 32'(e), 32'd1);
    do_read(0, 16'hFFFF, d, e, nb, nv);
    chk("oorFFFF_err", 32'(e), 32'd1);
    do_read(0, 16'd31, d, e, nb, nv);
    chk("edge31_data", 32'(d), 32'd31);
    chk("edge31_err", 32'(e), 32'd0);
    do_read(0, 16'd32, d, e, nb, nv);
    chk("edge32_err", 32'(e), 32'd1);

    // RD_LAT = 3
    do_read(1, 16'd2, d, e, nb, nv);
    chk("lat3_data", 32'(d), 32'h0002);
    chk("lat3_busy", 32'(nb), 32'd4);
    chk("lat3_pulses", 32'(nv), 32'd1);

    // Reset during WAIT cancels the read
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 16'd2;
    @(posedge clk);                // E0
    #1 req_valid[1] = 1'b0;
    @(posedge clk);                // E0+1
    #1 rst_n[1] = 1'b0;
    @(posedge clk);                // E0+2, reset edge
    #1 rst_n[1] = 1'b1;
    @(negedge clk);
    chk("rstwait_ready", 32'(req_ready[1]), 32'd1);
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[1]) nv++;
    end
    chk("rstwait_pulses", 32'(nv), 32'd0);

    // Randomized traffic, including requests while busy and occasional resets
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 400; n++) begin
        req_valid[k] = ($urandom % 3) != 0;
        req_wr[k]    = ($urandom % 2) != 0;
        req_addr[k]  = ($urandom % 8 == 0) ? 16'(32 + $urandom % 65504) : 16'($urandom % 32);
        req_wdata[k] = 16'($urandom);
        req_be[k]    = 2'($urandom);
        rst_n[k]     = ($urandom % 50) != 0;
        @(posedge clk); #1;
      end
      req_valid[k] = 1'b0; rst_n[k] = 1'b1;
      repeat (6) @(posedge clk);
    end

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
